// File: rtl/merger_ctrl_s_axi_pkg.sv
// Shared register map, FSM state types and CTRL bit positions for the merger control slave.
package merger_ctrl_s_axi_pkg;

    localparam logic [5:0] ADDR_CTRL      = 6'h00;
    localparam logic [5:0] ADDR_GIE       = 6'h04;
    localparam logic [5:0] ADDR_IER       = 6'h08;
    localparam logic [5:0] ADDR_ISR       = 6'h0C;
    localparam logic [5:0] ADDR_SIZE_LO   = 6'h10;
    localparam logic [5:0] ADDR_SIZE_HI   = 6'h14;
    localparam logic [5:0] ADDR_NPASS     = 6'h18;
    localparam logic [5:0] ADDR_INPTR_LO  = 6'h1C;
    localparam logic [5:0] ADDR_INPTR_HI  = 6'h20;
    localparam logic [5:0] ADDR_OUTPTR_LO = 6'h24;
    localparam logic [5:0] ADDR_OUTPTR_HI = 6'h28;
    localparam logic [5:0] ADDR_KRST      = 6'h2C;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_DONE_BIT  = 1;
    localparam int CTRL_IDLE_BIT  = 2;

    typedef enum logic [1:0] {
        WIDLE = 2'd0,
        WDATA = 2'd1,
        WRESP = 2'd2
    } wstate_t;

    typedef enum logic {
        RIDLE = 1'b0,
        RDATA = 1'b1
    } rstate_t;

    // Word-aligned form of a byte address; only bits [5:2] are decoded.
    function automatic logic [5:0] word_addr(input logic [5:0] a);
        return {a[5:2], 2'b00};
    endfunction

endpackage

// File: rtl/merger_ctrl_s_axi_reg64.sv
// One 64-bit register exposed as lo/hi 32-bit words with byte-strobed writes.
module merger_ctrl_reg64 (
    input  logic        ap_clk,
    input  logic        areset,
    input  logic        we_lo_i,
    input  logic        we_hi_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    output logic [63:0] val_o
);

    logic [63:0] val_q;
    logic [63:0] val_d;

    always_comb begin
        val_d = val_q;
        for (int b = 0; b < 4; b++) begin
            if (we_lo_i && wstrb_i[b]) val_d[8*b +: 8]      = wdata_i[8*b +: 8];
            if (we_hi_i && wstrb_i[b]) val_d[32 + 8*b +: 8] = wdata_i[8*b +: 8];
        end
    end

    always_ff @(posedge ap_clk) begin
        if (areset) val_q <= '0;
        else        val_q <= val_d;
    end

    assign val_o = val_q;

endmodule

// File: rtl/merger_ctrl_s_axi.sv
// AXI4-Lite control slave for the merger-tree wrapper: start/done/idle handshake, sizes, pointers.
// Define MERGER_CTRL_IRQ_EN to build the GIE/IER/ISR interrupt block; otherwise interrupt is 0.
module merger_ctrl_s_axi
    import merger_ctrl_s_axi_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                            ap_clk,
    input  logic                            areset,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    output logic [1:0]                      s_axi_bresp,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            ap_start,
    input  logic                            ap_done,
    input  logic                            ap_idle,
    output logic                            kernel_rst,
    output logic [63:0]                     size,
    output logic [7:0]                      num_pass,
    output logic [63:0]                     in_ptr,
    output logic [63:0]                     out_ptr,
    output logic                            interrupt
);

    wstate_t     wstate_q, wstate_d;
    rstate_t     rstate_q, rstate_d;
    logic [5:0]  waddr_q, waddr_d;
    logic [5:0]  raddr_q, raddr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] rd_mux;

    logic        start_q, start_d;
    logic        done_q, done_d;
    logic [7:0]  npass_q, npass_d;
    logic        krst_q, krst_d;

    logic        wr_fire;
    logic        rd_ctrl_fire;
    logic        unused_ok;

    assign unused_ok = ^{s_axi_awaddr, s_axi_araddr};

    assign wr_fire      = (wstate_q == WDATA) && s_axi_wvalid;
    assign rd_ctrl_fire = (rstate_q == RDATA) && s_axi_rready && (raddr_q == ADDR_CTRL);

    // Write channel
    always_comb begin
        wstate_d = wstate_q;
        waddr_d  = waddr_q;
        case (wstate_q)
            WIDLE: if (s_axi_awvalid) begin
                waddr_d  = word_addr(s_axi_awaddr[5:0]);
                wstate_d = WDATA;
            end
            WDATA: if (s_axi_wvalid) wstate_d = WRESP;
            WRESP: if (s_axi_bready) wstate_d = WIDLE;
            default: wstate_d = WIDLE;
        endcase
    end

    // Read channel: rdata is captured at the AR handshake and held until R completes.
    always_comb begin
        rstate_d = rstate_q;
        raddr_d  = raddr_q;
        rdata_d  = rdata_q;
        case (rstate_q)
            RIDLE: if (s_axi_arvalid) begin
                raddr_d  = word_addr(s_axi_araddr[5:0]);
                rdata_d  = rd_mux;
                rstate_d = RDATA;
            end
            RDATA: if (s_axi_rready) rstate_d = RIDLE;
            default: rstate_d = RIDLE;
        endcase
    end

    // Set terms are applied last so a done pulse or start write wins over a same-cycle clear.
    always_comb begin
        start_d = start_q;
        done_d  = done_q;
        npass_d = npass_q;
        krst_d  = krst_q;
        if (ap_done) start_d = 1'b0;
        if (wr_fire && (waddr_q == ADDR_CTRL) && s_axi_wstrb[0] && s_axi_wdata[CTRL_START_BIT])
            start_d = 1'b1;
        if (rd_ctrl_fire) done_d = 1'b0;
        if (ap_done)      done_d = 1'b1;
        if (wr_fire && (waddr_q == ADDR_NPASS) && s_axi_wstrb[0]) npass_d = s_axi_wdata[7:0];
        if (wr_fire && (waddr_q == ADDR_KRST)  && s_axi_wstrb[0]) krst_d  = s_axi_wdata[0];
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            wstate_q <= WIDLE;
            rstate_q <= RIDLE;
            waddr_q  <= '0;
            raddr_q  <= '0;
            rdata_q  <= '0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            npass_q  <= '0;
            krst_q   <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
            waddr_q  <= waddr_d;
            raddr_q  <= raddr_d;
            rdata_q  <= rdata_d;
            start_q  <= start_d;
            done_q   <= done_d;
            npass_q  <= npass_d;
            krst_q   <= krst_d;
        end
    end

    merger_ctrl_reg64 u_size (
        .ap_clk  (ap_clk),
        .areset  (areset),
        .we_lo_i (wr_fire && (waddr_q == ADDR_SIZE_LO)),
        .we_hi_i (wr_fire && (waddr_q == ADDR_SIZE_HI)),
        .wdata_i (s_axi_wdata),
        .wstrb_i (s_axi_wstrb),
        .val_o   (size)
    );

    merger_ctrl_reg64 u_in_ptr (
        .ap_clk  (ap_clk),
        .areset  (areset),
        .we_lo_i (wr_fire && (waddr_q == ADDR_INPTR_LO)),
        .we_hi_i (wr_fire && (waddr_q == ADDR_INPTR_HI)),
        .wdata_i (s_axi_wdata),
        .wstrb_i (s_axi_wstrb),
        .val_o   (in_ptr)
    );

    merger_ctrl_reg64 u_out_ptr (
        .ap_clk  (ap_clk),
        .areset  (areset),
        .we_lo_i (wr_fire && (waddr_q == ADDR_OUTPTR_LO)),
        .we_hi_i (wr_fire && (waddr_q == ADDR_OUTPTR_HI)),
        .wdata_i (s_axi_wdata),
        .wstrb_i (s_axi_wstrb),
        .val_o   (out_ptr)
    );

`ifdef MERGER_CTRL_IRQ_EN
    logic       gie_q, gie_d;
    logic [1:0] ier_q, ier_d;
    logic [1:0] isr_q, isr_d;
    logic       irq_q;

    always_comb begin
        gie_d = gie_q;
        ier_d = ier_q;
        isr_d = isr_q;
        if (wr_fire && (waddr_q == ADDR_GIE) && s_axi_wstrb[0]) gie_d = s_axi_wdata[0];
        if (wr_fire && (waddr_q == ADDR_IER) && s_axi_wstrb[0]) ier_d = s_axi_wdata[1:0];
        for (int i = 0; i < 2; i++) begin
            if (wr_fire && (waddr_q == ADDR_ISR) && s_axi_wstrb[0] && s_axi_wdata[i])
                isr_d[i] = ~isr_q[i];
            if (ap_done && ier_q[i]) isr_d[i] = 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            gie_q <= 1'b0;
            ier_q <= '0;
            isr_q <= '0;
            irq_q <= 1'b0;
        end else begin
            gie_q <= gie_d;
            ier_q <= ier_d;
            isr_q <= isr_d;
            irq_q <= gie_q & |(ier_q & isr_q);
        end
    end

    assign interrupt = irq_q;
`else
    assign interrupt = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (word_addr(s_axi_araddr[5:0]))
            ADDR_CTRL: begin
                rd_mux[CTRL_START_BIT] = start_q;
                rd_mux[CTRL_DONE_BIT]  = done_q;
                rd_mux[CTRL_IDLE_BIT]  = ap_idle;
            end
`ifdef MERGER_CTRL_IRQ_EN
            ADDR_GIE:       rd_mux[0]   = gie_q;
            ADDR_IER:       rd_mux[1:0] = ier_q;
            ADDR_ISR:       rd_mux[1:0] = isr_q;
`endif
            ADDR_SIZE_LO:   rd_mux = size[31:0];
            ADDR_SIZE_HI:   rd_mux = size[63:32];
            ADDR_NPASS:     rd_mux[7:0] = npass_q;
            ADDR_INPTR_LO:  rd_mux = in_ptr[31:0];
            ADDR_INPTR_HI:  rd_mux = in_ptr[63:32];
            ADDR_OUTPTR_LO: rd_mux = out_ptr[31:0];
            ADDR_OUTPTR_HI: rd_mux = out_ptr[63:32];
            ADDR_KRST:      rd_mux[0] = krst_q;
            default:        rd_mux = '0;
        endcase
    end

    assign s_axi_awready = (wstate_q == WIDLE);
    assign s_axi_wready  = (wstate_q == WDATA);
    assign s_axi_bvalid  = (wstate_q == WRESP);
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = (rstate_q == RIDLE);
    assign s_axi_rvalid  = (rstate_q == RDATA);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;

    assign ap_start   = start_q;
    assign kernel_rst = krst_q;
    assign num_pass   = npass_q;

endmodule
